// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - opcode / funct encodings understood by the decoder
//   - ALU operation codes (existing ALU encoding, ADD=0 .. SLTU=9)
//   - FSM state enum
//   - mux select codes for ALU operand B, PC source and trap cause
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [3:0] {
    RESET    = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    EXEC_I   = 4'd8,
    ALU_WB   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_BR_OFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  function automatic logic is_alu_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_ANDI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decode.
// Ports:
//   opcode      in  6  instruction opcode
//   funct       in  6  R-type function field
//   alu_op_r    out 4  ALU code for an R-type instruction (from funct)
//   alu_op_i    out 4  ALU code for an immediate ALU instruction (from opcode)
//   funct_legal out 1  funct is one of the supported R-type operations
module alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op_r,
  output logic [3:0] alu_op_i,
  output logic       funct_legal
);

  always_comb begin
    alu_op_r    = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  alu_op_r = ALU_ADD;
      FN_ADDU: alu_op_r = ALU_ADDU;
      FN_SUB:  alu_op_r = ALU_SUB;
      FN_SUBU: alu_op_r = ALU_SUBU;
      FN_AND:  alu_op_r = ALU_AND;
      FN_OR:   alu_op_r = ALU_OR;
      FN_XOR:  alu_op_r = ALU_XOR;
      FN_NOR:  alu_op_r = ALU_NOR;
      FN_SLT:  alu_op_r = ALU_SLT;
      FN_SLTU: alu_op_r = ALU_SLTU;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_op_i = ALU_ADD;
    case (opcode)
      OP_ORI:  alu_op_i = ALU_OR;
      OP_ANDI: alu_op_i = ALU_AND;
      OP_SLTI: alu_op_i = ALU_SLT;
      default: alu_op_i = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback over one shared memory port and one ALU.
// Optional performance counters are enabled with macro MC_CTRL_PERF_EN.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   opcode, funct       instruction fields from the IR
//   mem_ready           memory completes the current access this cycle
//   pc_write, pc_write_cond, branch_ne, pc_source   PC update controls
//   iord, mem_read, mem_write, ir_write             memory / IR controls
//   reg_dst, mem_to_reg, reg_write                  register file controls
//   alu_src_a, alu_src_b, zero_ext, alu_op          ALU controls
//   instr_done          pulse in an instruction's final state
//   trap, trap_cause    sticky trap flag and cause (01 illegal, 10 timeout)
//   cycle_cnt, instr_cnt  performance counters (MC_CTRL_PERF_EN only)
//
// state    | meaning
// ---------+-----------------------------------------------
// RESET    | one idle cycle after reset, all outputs 0
// FETCH    | read instruction at PC, PC += 4 on mem_ready
// DECODE   | compute branch target, dispatch on opcode
// MEM_ADDR | effective address = A + imm
// MEM_RD   | load data read, wait for mem_ready
// MEM_WB   | write MDR to rt
// MEM_WR   | store write, wait for mem_ready
// EXEC_R   | R-type ALU operation
// EXEC_I   | immediate ALU operation
// ALU_WB   | write ALUOut to rd (R-type) or rt
// BRANCH   | compare A-B, conditional PC load
// JUMP     | PC = jump target
// TRAP     | illegal instruction or memory timeout, absorbing
module multi_cycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W   = 4,
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                zero_ext,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                trap,
`ifdef MC_CTRL_PERF_EN
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt,
`endif
  output logic [1:0]          trap_cause
);

  // Counter only needs to reach WAIT_LIMIT-1; keep at least one bit.
  localparam int WCNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_t              state_q, state_d;
  logic                rtype_q;
  logic                trap_q;
  logic [1:0]          trap_cause_q;
  logic [WCNT_W-1:0]   wait_cnt_q;
  logic                in_wait;
  logic                timeout;
  logic                enter_trap;
  logic [3:0]          alu_code;
  logic [3:0]          alu_op_r, alu_op_i;
  logic                funct_legal;

  alu_op_decode u_alu_op_decode (
    .opcode      (opcode),
    .funct       (funct),
    .alu_op_r    (alu_op_r),
    .alu_op_i    (alu_op_i),
    .funct_legal (funct_legal)
  );

  assign in_wait = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

  // The limit cycle is the one whose stall would push the count to
  // WAIT_LIMIT; a mem_ready in that same cycle still completes normally.
  assign timeout = (WAIT_LIMIT > 0) && in_wait && !mem_ready &&
                   (wait_cnt_q == WCNT_W'(WAIT_LIMIT - 1));

  assign enter_trap = (state_d == TRAP) && (state_q != TRAP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:    state_d = FETCH;
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW)       state_d = MEM_ADDR;
        else if (opcode == OP_RTYPE)                  state_d = funct_legal ? EXEC_R : TRAP;
        else if (is_alu_imm(opcode))                  state_d = EXEC_I;
        else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = BRANCH;
        else if (opcode == OP_J)                      state_d = JUMP;
        else                                          state_d = TRAP;
      end
      MEM_ADDR: state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_d = MEM_WB;
      MEM_WB:   state_d = FETCH;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      EXEC_R:   state_d = ALU_WB;
      EXEC_I:   state_d = ALU_WB;
      ALU_WB:   state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = RESET;
    endcase
    if (timeout) state_d = TRAP;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCSRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REG;
    zero_ext      = 1'b0;
    alu_code      = ALU_ADD;
    instr_done    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = ALUB_BR_OFS;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_code  = alu_op_r;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_code  = alu_op_i;
        zero_ext  = (opcode == OP_ORI) || (opcode == OP_ANDI);
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = rtype_q;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_code      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op     = ALU_OP_W'(alu_code);
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET;
      rtype_q      <= 1'b0;
      trap_q       <= 1'b0;
      trap_cause_q <= TRAP_NONE;
      wait_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) rtype_q <= (opcode == OP_RTYPE);
      if (enter_trap) begin
        trap_q       <= 1'b1;
        trap_cause_q <= timeout ? TRAP_TIMEOUT : TRAP_ILLEGAL;
      end
      // Staying in a wait state implies a stalled cycle; any transition
      // (including entry) restarts the count.
      if (in_wait && (state_d == state_q)) wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
      else                                 wait_cnt_q <= '0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_q != RESET && state_q != TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done)                          instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed testbench for multi_cycle_control (WAIT_LIMIT = 4).
module tb_multi_cycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [3:0] alu_op;
    logic       instr_done;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_source;
  logic       iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b;
  logic       zero_ext;
  logic [3:0] alu_op;
  logic       instr_done, trap;
  logic [1:0] trap_cause;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multi_cycle_control #(.ALU_OP_W(4), .WAIT_LIMIT(4), .CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct         (funct),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .zero_ext      (zero_ext),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .trap          (trap),
`ifdef MC_CTRL_PERF_EN
    .cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt),
`endif
    .trap_cause    (trap_cause)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ctl_t snap [0:63];
  logic trap_s [0:63];
  logic [1:0] cause_s [0:63];
  int   n_cyc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t sample_ctl();
    return {pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read, mem_write,
            ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, zero_ext,
            alu_op, instr_done};
  endfunction

  task automatic cycle(input logic rdy);
    @(posedge clk);
    #1 mem_ready = rdy;
    #1;
  endtask

  // Run one instruction; bit i of mask is mem_ready in cycle i.
  // Stops at instr_done or trap; n_cyc stays 0 if neither appears.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [63:0] mask);
    opcode = op;
    funct  = fn;
    n_cyc  = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(mask[i]);
      snap[i]    = sample_ctl();
      trap_s[i]  = trap;
      cause_s[i] = trap_cause;
      if (snap[i].instr_done || trap) begin
        n_cyc = i + 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m2r;
    int bad;
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b0;
    #3;
    check_val("reset_ctl", 32'(sample_ctl()), 32'd0);
    check_val("reset_trap", {30'd0, trap_cause}, 32'd0);
`ifdef MC_CTRL_PERF_EN
    check_val("reset_cnt", cycle_cnt | instr_cnt, 32'd0);
`endif
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;

    // ADD, no waits: FETCH DECODE EXEC_R ALU_WB
    run_instr(6'b000000, 6'b100000, '1);
    check_val("add_cycles", n_cyc, 4);
    check_val("add_fetch", {snap[0].mem_read, snap[0].ir_write, snap[0].pc_write, snap[0].alu_src_b, snap[0].iord}, 6'b111010);
    check_val("add_decode", {snap[1].alu_src_a, snap[1].alu_src_b, snap[1].alu_op}, 7'b0110000);
    check_val("add_exec", {snap[2].alu_src_a, snap[2].alu_src_b, snap[2].alu_op}, 7'b1000000);
    check_val("add_wb", {snap[3].reg_dst, snap[3].reg_write, snap[3].mem_to_reg}, 3'b110);
`ifdef MC_CTRL_PERF_EN
    check_val("perf_cycle", cycle_cnt, 32'd3);
`endif

    run_instr(6'b000000, 6'b100010, '1);
    check_val("sub_alu_op", snap[2].alu_op, 4'd2);
    run_instr(6'b000000, 6'b101011, '1);
    check_val("sltu_alu_op", snap[2].alu_op, 4'd9);

    // LW with 3 stall cycles in MEM_RD
    run_instr(6'b100011, 6'd0, 64'hFFFF_FFFF_FFFF_FFC7);
    check_val("lw_cycles", n_cyc, 8);
    m2r = 0;
    for (int i = 0; i < 8; i++) m2r += int'(snap[i].mem_to_reg);
    check_val("lw_m2r_count", m2r, 1);
    check_val("lw_memwb", {snap[7].mem_to_reg, snap[7].reg_write, snap[7].reg_dst}, 3'b110);
    check_val("lw_memrd", {snap[4].mem_read, snap[4].iord}, 2'b11);
    check_val("lw_addr", {snap[2].alu_src_a, snap[2].alu_src_b}, 3'b110);
    check_val("lw_no_trap", trap, 1'b0);

    run_instr(6'b101011, 6'd0, '1);
    check_val("sw_cycles", n_cyc, 4);
    check_val("sw_wr", {snap[3].mem_write, snap[3].iord, snap[3].reg_write}, 3'b110);

    run_instr(6'b001101, 6'd0, '1);
    check_val("ori_exec", {snap[2].zero_ext, snap[2].alu_src_b, snap[2].alu_op}, 7'b1100101);
    check_val("ori_wb", {snap[3].reg_dst, snap[3].reg_write}, 2'b01);
    run_instr(6'b001010, 6'd0, '1);
    check_val("slti_exec", {snap[2].zero_ext, snap[2].alu_op}, 5'b01000);
    run_instr(6'b001100, 6'd0, '1);
    check_val("andi_exec", {snap[2].zero_ext, snap[2].alu_op}, 5'b10100);

    run_instr(6'b000101, 6'd0, '1);
    check_val("bne_cycles", n_cyc, 3);
    check_val("bne_branch", {snap[2].pc_write_cond, snap[2].branch_ne, snap[2].pc_source, snap[2].alu_op, snap[2].pc_write}, 9'b110100100);
    run_instr(6'b000100, 6'd0, '1);
    check_val("beq_branch", {snap[2].pc_write_cond, snap[2].branch_ne}, 2'b10);

    run_instr(6'b000010, 6'd0, '1);
    check_val("j_cycles", n_cyc, 3);
    check_val("j_jump", {snap[2].pc_write, snap[2].pc_source}, 3'b110);

    // mem_ready arrives on the 4th FETCH cycle: the limit cycle, no trap
    run_instr(6'b000010, 6'd0, 64'hFFFF_FFFF_FFFF_FFF8);
    check_val("wd_edge_cycles", n_cyc, 6);
    check_val("wd_edge_no_trap", {trap_s[5], snap[3].ir_write}, 2'b01);

    // Reset asserted while MEM_WR waits
    opcode = 6'b101011;
    cycle(1'b1); cycle(1'b1); cycle(1'b0); cycle(1'b0);
    check_val("memwr_active", mem_write, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_val("memwr_async_drop", mem_write, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    check_val("reset_state_ctl", 32'(sample_ctl()), 32'd0);
`ifdef MC_CTRL_PERF_EN
    check_val("reset_mid_cnt", cycle_cnt | instr_cnt, 32'd0);
`endif

    // Illegal opcode: first cycle must be FETCH right after the RESET cycle
    run_instr(6'b111111, 6'd0, '1);
    check_val("ill_fetch_after_reset", snap[0].mem_read, 1'b1);
    check_val("ill_cycles", n_cyc, 3);
    check_val("ill_decode_no_trap", trap_s[1], 1'b0);
    check_val("ill_trap", {trap_s[2], cause_s[2]}, 3'b101);
    check_val("ill_enables", 32'(snap[2]), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom_range(0, 1)));
      if (sample_ctl() != '0 || trap !== 1'b1 || trap_cause !== 2'b01) bad++;
    end
    check_val("ill_hold", bad, 0);

    do_reset();
    check_val("trap_cleared", {29'd0, trap, trap_cause}, 32'd0);

    // mem_ready stuck low in FETCH: 4 wait cycles then TRAP with timeout
    run_instr(6'b000010, 6'd0, '0);
    check_val("wd_cycles", n_cyc, 5);
    check_val("wd_pre", {trap_s[3], snap[3].mem_read}, 2'b01);
    check_val("wd_trap", {trap_s[4], cause_s[4]}, 3'b110);

    do_reset();
    run_instr(6'b000000, 6'b000000, '1);
    check_val("bad_funct_trap", {trap_s[2], cause_s[2], 6'(n_cyc)}, {3'b101, 6'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
